// File: rtl/axis_variable_pkg.sv
// axis_variable_pkg
// Shared definitions for axis_variable_multi:
//   clog2_min1  - ceil(log2(n)) clamped to at least 1, used for index widths
//   out_state_e - output-stage state (EMPTY: no beat held, FULL: beat on the bus)
package axis_variable_pkg;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/axis_variable_multi_if.sv
// axis_variable_multi_if
// AXI4-Stream bundle carrying one channel update per beat.
//   tdata  - channel value
//   tuser  - channel index
//   tvalid - beat valid
//   tready - sink ready
// Handshake: a beat transfers on a clock edge where tvalid && tready. Once
// tvalid is raised it stays high, and tdata/tuser stay stable, until that
// transfer happens. tready may change freely and never depends on tvalid
// rising first.
interface axis_variable_multi_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 2
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter
// Round-robin selector over N request lines.
//   aclk, aresetn - clock, asynchronous active-low reset
//   req           - request vector
//   advance       - the current grant was taken; it becomes lowest priority
//   grant         - index of the first requester after the last taken grant
// grant is only meaningful while |req. After reset the last grant is N-1,
// so index 0 is searched first.
module axis_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [W-1:0] grant
);
    logic [W-1:0] last_grant;
    logic [W-1:0] idx;

    // Walk from farthest to nearest so the nearest requester after
    // last_grant is the one left in grant.
    always_comb begin
        grant = last_grant;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(last_grant) + k) % N);
            if (req[idx]) grant = idx;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant <= W'(N - 1);
        end else if (advance) begin
            last_grant <= grant;
        end
    end
endmodule

// File: rtl/axis_variable_multi.sv
// axis_variable_multi
// Watches CHANNELS configuration words and streams one AXIS beat per changed
// channel (tuser = channel index). Back-pressure is honoured; changes that
// arrive while an update is still pending are merged into it, so the beat
// always carries the latest value.
// Ports:
//   aclk, aresetn - clock, asynchronous active-low reset
//   cfg_data      - channel i at [i*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH]
//   cfg_force     - level-sampled, marks every channel pending
//   m_axis        - AXIS master (tdata, tuser, tvalid, tready)
//   coalesced     - per-channel pulse when a change merged into a pending update
//   dbg_state     - output-stage state
// Build option: AXIS_VARIABLE_REFRESH_EN adds a free-running counter that
// rebroadcasts all channels every REFRESH_PERIOD cycles.
module axis_variable_multi
    import axis_variable_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CHANNELS         = 4,
    parameter int REFRESH_PERIOD   = 1000000
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] cfg_data,
    input  logic                                 cfg_force,
    axis_variable_multi_if.master                m_axis,
    output logic [CHANNELS-1:0]                  coalesced,
    output out_state_e                           dbg_state
);
    localparam int W        = AXIS_TDATA_WIDTH;
    localparam int CH_WIDTH = clog2_min1(CHANNELS);
    localparam int RP_W     = clog2_min1(REFRESH_PERIOD);

    logic [W-1:0]        snap [CHANNELS];
    logic [CHANNELS-1:0] change;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] set_vec;
    logic [CHANNELS-1:0] clr_vec;
    logic [CH_WIDTH-1:0] grant;
    logic                refresh_tick;
    logic                can_accept;
    logic                load;
    out_state_e          state;

`ifdef AXIS_VARIABLE_REFRESH_EN
    logic [RP_W-1:0] refresh_cnt;

    assign refresh_tick = (refresh_cnt == RP_W'(REFRESH_PERIOD - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_tick ? '0 : refresh_cnt + 1'b1;
        end
    end
`else
    assign refresh_tick = 1'b0;
`endif

    always_comb begin
        change = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            change[i] = (cfg_data[i*W +: W] != snap[i]);
        end
    end

    assign set_vec    = change | {CHANNELS{cfg_force | refresh_tick}};
    assign can_accept = (state == ST_EMPTY) || m_axis.tready;
    assign load       = can_accept && (|pending);

    always_comb begin
        clr_vec = '0;
        if (load) clr_vec[grant] = 1'b1;
    end

    axis_rr_arbiter #(
        .N (CHANNELS),
        .W (CH_WIDTH)
    ) u_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (pending),
        .advance (load),
        .grant   (grant)
    );

    // Set wins over clear: a channel that changes while being loaded stays
    // pending and is re-sent with the newer value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < CHANNELS; i++) snap[i] <= '0;
            pending   <= '0;
            coalesced <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) snap[i] <= cfg_data[i*W +: W];
            pending   <= set_vec | (pending & ~clr_vec);
            coalesced <= change & pending & ~clr_vec;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_EMPTY;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tuser  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (|pending) begin
                        state         <= ST_FULL;
                        m_axis.tvalid <= 1'b1;
                        m_axis.tdata  <= snap[grant];
                        m_axis.tuser  <= grant;
                    end
                end
                ST_FULL: begin
                    if (m_axis.tready) begin
                        if (|pending) begin
                            m_axis.tdata <= snap[grant];
                            m_axis.tuser <= grant;
                        end else begin
                            state         <= ST_EMPTY;
                            m_axis.tvalid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= ST_EMPTY;
                    m_axis.tvalid <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_axis_variable_multi.sv
module tb_axis_variable_multi;
  import axis_variable_pkg::*;

  localparam int W  = 32;
  localparam int CH = 4;
  localparam int UW = 2;
  localparam int RP = 64;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [CH*W-1:0] cfg_data;
  logic            cfg_force;
  logic [CH-1:0]   coalesced;
  out_state_e      dbg_state;

  axis_variable_multi_if #(.DATA_W(W), .USER_W(UW)) m_axis ();

  axis_variable_multi #(
    .AXIS_TDATA_WIDTH (W),
    .CHANNELS         (CH),
    .REFRESH_PERIOD   (RP)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cfg_data  (cfg_data),
    .cfg_force (cfg_force),
    .m_axis    (m_axis.master),
    .coalesced (coalesced),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int coal2_cnt = 0;
  logic [W-1:0] exp_q[$];     // data of every accepted beat, in order
  int           exp_user_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Abstract view: a table of last-seen values, a set of dirty channels,
  // a one-entry output slot and a rotating pointer.
  logic [W-1:0] m_snap [CH];
  bit           m_dirty [CH];
  bit           m_coal [CH];
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_user;
  int           m_last;
  int           m_cnt;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_snap[i] = '0; m_dirty[i] = 0; m_coal[i] = 0;
    end
    m_valid = 0; m_data = '0; m_user = 0; m_last = CH - 1; m_cnt = 0;
  endtask

  task automatic model_step();
    bit tick;
    bit chg [CH];
    bit any;
    bit take;
    int g;
    tick = 0;
`ifdef AXIS_VARIABLE_REFRESH_EN
    tick  = (m_cnt == RP - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
`endif
    any = 0;
    for (int i = 0; i < CH; i++) begin
      chg[i] = (cfg_data[i*W +: W] != m_snap[i]);
      if (m_dirty[i]) any = 1;
    end
    if (m_valid && m_axis.tready) begin
      exp_q.push_back(m_data);
      exp_user_q.push_back(m_user);
    end
    take = (!m_valid || m_axis.tready) && any;
    g = -1;
    if (take) begin
      for (int k = 1; k <= CH; k++) begin
        if (g < 0 && m_dirty[(m_last + k) % CH]) g = (m_last + k) % CH;
      end
    end
    if (g >= 0) begin
      m_data  = m_snap[g];
      m_user  = g;
      m_last  = g;
      m_valid = 1;
    end else if (!m_valid || m_axis.tready) begin
      m_valid = 0;
    end
    for (int i = 0; i < CH; i++) begin
      m_coal[i]  = chg[i] && m_dirty[i] && (g != i);
      m_dirty[i] = chg[i] || cfg_force || tick || (m_dirty[i] && (g != i));
      m_snap[i]  = cfg_data[i*W +: W];
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(posedge aclk) begin
    if (!aresetn) model_reset();
    else model_step();
    #1;
    chk("tvalid", 64'(m_axis.tvalid), 64'(m_valid));
    chk("tdata", 64'(m_axis.tdata), 64'(m_data));
    chk("tuser", 64'(m_axis.tuser), 64'(m_user));
    for (int i = 0; i < CH; i++) chk($sformatf("coalesced%0d", i), 64'(coalesced[i]), 64'(m_coal[i]));
    chk("state", 64'(dbg_state), 64'(m_valid ? ST_FULL : ST_EMPTY));
    coal2_cnt += int'(coalesced[2]);
  end

  // ---------------- driver helpers ----------------
  task automatic set_ch(input int ch, input logic [W-1:0] v);
    cfg_data[ch*W +: W] = v;
  endtask

  task automatic clear_log();
    exp_q.delete();
    exp_user_q.delete();
  endtask

  function automatic int beats_of(input int u);
    int n = 0;
    foreach (exp_user_q[i]) if (exp_user_q[i] == u) n++;
    return n;
  endfunction

  function automatic logic [W-1:0] data_of(input int u);
    logic [W-1:0] d = '0;
    foreach (exp_user_q[i]) if (exp_user_q[i] == u) d = exp_q[i];
    return d;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int exp_refresh;
    aresetn = 1'b0;
    cfg_data = '0;
    cfg_force = 1'b0;
    m_axis.tready = 1'b0;
    model_reset();
    repeat (3) @(negedge aclk);

    // reset values
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis.tdata), 64'd0);
    chk("rst_tuser", 64'(m_axis.tuser), 64'd0);
    chk("rst_coalesced", 64'(coalesced), 64'd0);

    // single non-zero channel after reset release
    set_ch(1, 32'h5);
    m_axis.tready = 1'b1;
    clear_log();
    aresetn = 1'b1;
    @(posedge aclk);
    @(posedge aclk);
    #2;
    chk("t1_tvalid", 64'(m_axis.tvalid), 64'd1);
    chk("t1_tdata", 64'(m_axis.tdata), 64'h5);
    chk("t1_tuser", 64'(m_axis.tuser), 64'd1);
    @(posedge aclk);
    #2;
    chk("t1_idle", 64'(m_axis.tvalid), 64'd0);
    repeat (4) @(negedge aclk);
    chk("t1_beats", 64'(exp_q.size()), 64'd1);

    // three channels change together
    clear_log();
    set_ch(0, 32'hA0); set_ch(2, 32'hB2); set_ch(3, 32'hC3);
    repeat (8) @(negedge aclk);
    chk("t2_beats", 64'(exp_q.size()), 64'd3);
    chk("t2_ch0", 64'(data_of(0)), 64'hA0);
    chk("t2_ch2", 64'(data_of(2)), 64'hB2);
    chk("t2_ch3", 64'(data_of(3)), 64'hC3);
    chk("t2_no_ch1", 64'(beats_of(1)), 64'd0);

    // coalescing under back-pressure
    clear_log();
    m_axis.tready = 1'b0;
    set_ch(0, 32'h5A);
    @(negedge aclk);
    @(negedge aclk);
    coal2_cnt = 0;
    set_ch(2, 32'h10);
    @(negedge aclk);
    set_ch(2, 32'h11);
    @(negedge aclk);
    set_ch(2, 32'h12);
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk);
      #2;
      chk("t3_stall_valid", 64'(m_axis.tvalid), 64'd1);
      chk("t3_stall_data", 64'(m_axis.tdata), 64'h5A);
      chk("t3_stall_user", 64'(m_axis.tuser), 64'd0);
    end
    @(negedge aclk);
    m_axis.tready = 1'b1;
    repeat (6) @(negedge aclk);
    chk("t3_coal_pulses", 64'(coal2_cnt), 64'd2);
    chk("t3_ch2_beats", 64'(beats_of(2)), 64'd1);
    chk("t3_ch2_data", 64'(data_of(2)), 64'h12);
    chk("t3_ch0_data", 64'(data_of(0)), 64'h5A);

    // forced rebroadcast with random back-pressure
    clear_log();
    cfg_force = 1'b1;
    @(negedge aclk);
    cfg_force = 1'b0;
    for (int i = 0; i < 60; i++) begin
      m_axis.tready = ($urandom_range(0, 2) != 0);
      @(negedge aclk);
    end
    m_axis.tready = 1'b1;
    repeat (4) @(negedge aclk);
    chk("t4_beats", 64'(exp_q.size()), 64'd4);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("t4_count%0d", c), 64'(beats_of(c)), 64'd1);
      chk($sformatf("t4_data%0d", c), 64'(data_of(c)), 64'(cfg_data[c*W +: W]));
    end

    // reset while a beat is held and other channels are pending
    m_axis.tready = 1'b0;
    set_ch(0, 32'h11); set_ch(1, 32'h22); set_ch(2, 32'h0); set_ch(3, 32'h33);
    repeat (2) @(negedge aclk);
    chk("t5_pre_valid", 64'(m_axis.tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("t5_async_valid", 64'(m_axis.tvalid), 64'd0);
    repeat (2) @(negedge aclk);
    clear_log();
    m_axis.tready = 1'b1;
    aresetn = 1'b1;
    repeat (10) @(negedge aclk);
    chk("t5_beats", 64'(exp_q.size()), 64'd3);
    chk("t5_no_ch2", 64'(beats_of(2)), 64'd0);
    chk("t5_ch3", 64'(data_of(3)), 64'h33);

    // random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      m_axis.tready = ($urandom_range(0, 3) != 0);
      cfg_force = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) set_ch(c, W'($urandom_range(0, 3)));
      end
      @(negedge aclk);
    end
    cfg_force = 1'b0;
    m_axis.tready = 1'b1;
    repeat (10) @(negedge aclk);

    // static configuration: only the refresh option produces traffic
    aresetn = 1'b0;
    set_ch(0, 32'h1); set_ch(1, 32'h2); set_ch(2, 32'h3); set_ch(3, 32'h4);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (10) @(negedge aclk);
    clear_log();
    repeat (200) @(negedge aclk);
`ifdef AXIS_VARIABLE_REFRESH_EN
    exp_refresh = 3 * CH;
`else
    exp_refresh = 0;
`endif
    chk("t6_refresh_beats", 64'(exp_q.size()), 64'(exp_refresh));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
